pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit for the single-cycle core; generalises two-way PC next/branch select.
//  Adds stall, halt/resume FSM, and call/return through an internal return-address stack (RAS).
//  Sits between instruction-memory address port and branch/control decode; PC feeds instr fetch.
// PARAMETERS
//  PC_W      8   PC / address width in bits
//  PC_INC    1   sequential increment (instr-memory word step)
//  RAS_DEPTH 4   return-address stack entries (power of 2, >=2)
//  RST_VEC   0   PC value loaded on reset
// PORTS
//  Clk          in   1     clock; all state updates on falling edge (matches datapath timing)
//  Reset        in   1     asynchronous, active-low reset
//  Stall        in   1     1 = hold PC and RAS this cycle
//  Branch       in   1     1 = taken branch/jump to Target
//  Call         in   1     1 = push PC+PC_INC, jump to Target
//  Ret          in   1     1 = pop RAS top into PC
//  Target       in   PC_W  branch/call destination
//  Halt         in   1     request halt (enter HALT)
//  Resume       in   1     leave HALT
//  PC           out  PC_W  current program counter
//  Halted       out  1     1 while FSM in HALT
//  Ras_Empty    out  1     RAS holds 0 entries
//  Ras_Full     out  1     RAS holds RAS_DEPTH entries
//  Ras_Err      out  1     sticky: overflow or underflow occurred since reset
// BEHAVIOUR
//  Reset (async, Reset==0): PC=RST_VEC, FSM=RUN, RAS count=0, Ras_Empty=1, Ras_Full=0, Ras_Err=0, Halted=0.
//  FSM states RUN, HALT. RUN->HALT when Halt=1 and Stall=0; HALT->RUN when Resume=1.
//   In HALT PC/RAS frozen, all control inputs except Resume ignored; Halt and Resume both 1 in HALT -> RUN.
//  RUN, per falling edge, priority Stall > Halt > Ret > Call > Branch > sequential:
//   Stall : PC, RAS unchanged.
//   Halt  : PC unchanged, enter HALT (the halting instruction is not advanced past).
//   Ret   : RAS nonempty -> PC=top, pop. Empty -> PC=PC+PC_INC, Ras_Err=1.
//   Call  : PC=Target, push PC+PC_INC. Full -> circular overwrite of oldest entry,
//           count stays RAS_DEPTH, Ras_Err=1.
//   Branch: PC=Target.
//   none  : PC=PC+PC_INC.
//  Lower-priority requests asserted same cycle are dropped (not queued).
//  Arithmetic: PC+PC_INC truncated to PC_W bits (wraps 2^PC_W-1 -> PC_INC-1).
//  Latency: PC visible one falling edge after request; Ras_* flags reflect post-update state.
//  Ras_Err cleared only by reset. Reset mid-halt or mid-call returns to reset state immediately.
// STRUCTURE
//  Shared package pc_pkg: FSM state encoding (RUN/HALT), next-PC source enum
//   (HOLD, RAS, TARGET, SEQ), default PC_W.
//  Sub-module pc_ras: circular LIFO, ports push/pop/din/top/empty/full/ovf/unf,
//   same clock edge and reset; pc_sequencer holds FSM, priority mux and Ras_Err.
// TESTING
//  Reset then 3 edges, no ctrl -> PC 0,1,2,3; Reset low mid-run -> PC=0 async.
//  PC=0xFE, free-run 3 edges -> 0xFF, 0x00, 0x01 (wrap).
//  PC=0x10 Call Target=0x40; PC=0x41 Ret -> PC=0x40 then 0x11; Ras_Empty=1, Ras_Err=0.
//  5 nested Calls (DEPTH 4) -> Ras_Full=1, Ras_Err=1; 4 Rets return the 4 newest addrs.
//  Ret with empty RAS at PC=0x20 -> PC=0x21, Ras_Err=1 sticky.
//  Halt at PC=0x05 -> Halted=1, PC held 0x05 under Branch/Call; Resume -> 0x06; Stall+Branch -> hold.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer:
// FSM state encoding, next-PC source select and default width.
package pc_pkg;

    localparam int PC_W_DEF = 8;

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    typedef enum logic [1:0] {
        HOLD,
        RAS,
        TARGET,
        SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the
// oldest entry, a pop when empty is ignored and flagged.
module pc_ras
    import pc_pkg::*;
#(
    parameter int W     = PC_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE  = 1;
    localparam logic [AW:0]   CMAX = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] ptr_q;
    logic [AW:0]   cnt_q;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CMAX);
    assign top   = mem_q[ptr_q - ONE];
    assign ovf   = push & full;
    assign unf   = pop & empty;

    // ptr_q always names the next free slot, so a full push lands on the oldest
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[ptr_q] <= din;
            ptr_q        <= ptr_q + ONE;
            if (!full) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - ONE;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: halt/resume FSM, stall, branch and
// call/return through an internal return-address stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              PC_INC    = 1,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RST_VEC   = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            Call,
    input  logic            Ret,
    input  logic [PC_W-1:0] Target,
    input  logic            Halt,
    input  logic            Resume,
    output logic [PC_W-1:0] PC,
    output logic            Halted,
    output logic            Ras_Empty,
    output logic            Ras_Full,
    output logic            Ras_Err
);

    state_e          state_q, state_d;
    pc_src_e         src;
    logic [PC_W-1:0] pc_q, pc_d, seq, top;
    logic            err_q, err_d;
    logic            push, pop, empty, full, ovf, unf;

    assign seq = pc_q + PC_W'(PC_INC);

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .din   (seq),
        .top   (top),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .unf   (unf)
    );

    // Stall > Halt > Ret > Call > Branch > sequential
    always_comb begin
        state_d = state_q;
        src     = HOLD;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!Stall) begin
                    if (Halt) begin
                        state_d = HALT;
                    end else if (Ret) begin
                        pop = 1'b1;
                        src = empty ? SEQ : RAS;
                    end else if (Call) begin
                        push = 1'b1;
                        src  = TARGET;
                    end else if (Branch) begin
                        src = TARGET;
                    end else begin
                        src = SEQ;
                    end
                end
            end
            HALT: begin
                if (Resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        unique case (src)
            HOLD:   pc_d = pc_q;
            RAS:    pc_d = top;
            TARGET: pc_d = Target;
            SEQ:    pc_d = seq;
        endcase
    end

    assign err_d = err_q | ovf | unf;

    always_ff @(negedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            pc_q    <= RST_VEC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign PC        = pc_q;
    assign Halted    = (state_q == HALT);
    assign Ras_Empty = empty;
    assign Ras_Full  = full;
    assign Ras_Err   = err_q;

endmodule
